pe_node_engine: RTL and testbench
=================================

PE_NODE_ENGINE -- requirements
Module: pe_node_engine

Interface
REQ-001 SHALL have parameter MY_ADDR, default 4'b0101, this node's 4-bit NoC address.
REQ-002 SHALL have parameter MEM_ADDR, default 4'b1101, the NoC address of the memory wrapper that receives results.
REQ-003 SHALL have parameter THRESHOLD, default 8'd64, the firing threshold for the membrane potential.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, exposed as ports clk and reset.
REQ-005 SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-007 SHALL have port in_packet, input, 33 bits, an incoming NoC packet: [32] type (0 = filter, 1 = ifmap), [31:28] dest, [27:24] src, [23:0] data.
REQ-008 SHALL have port in_valid, input, 1 bit, qualifying in_packet.
REQ-009 SHALL have port in_ready, output, 1 bit, set when the node can accept a packet.
REQ-010 SHALL have port out_packet, output, 33 bits, the result packet sent to memory.
REQ-011 SHALL have port out_valid, output, 1 bit, qualifying out_packet.
REQ-012 SHALL have port out_ready, input, 1 bit, the downstream NoC's accept signal.
REQ-013 SHALL have port potential_q, output, 8 bits, the stored membrane potential.
REQ-014 SHALL have port busy, output, 1 bit, high in every state except COLLECT.
REQ-015 SHALL have port err_dest, output, 1 bit, a one-cycle pulse when a packet addressed to another node is accepted.

Function
REQ-016 SHALL transfer a packet in a cycle only when valid and ready are both high at the rising clock edge.
REQ-017 SHALL use four states: COLLECT, MAC, UPDATE and SEND; in_ready SHALL be 1 only in COLLECT.
REQ-018 In COLLECT, a packet with type 0 SHALL store data[7:0], data[15:8] and data[23:16] as weights col0, col1 and col2 of the row selected by a 2-bit row counter.
REQ-019 After each filter write, the row counter SHALL advance 0→1→2→0, and filt_cnt SHALL increment, saturating at 3.
REQ-020 A 4th or later filter packet SHALL overwrite the row selected by the counter, with filt_cnt remaining 3.
REQ-021 An ifmap packet (type 1) SHALL latch data[8:0] as spikes, with bits [2:0] = row 0 (col0 in the LSB), [5:3] = row 1 and [8:6] = row 2, and SHALL set ifm_ok.
REQ-022 A repeated ifmap packet SHALL overwrite the stored spikes.
REQ-023 A packet with dest ≠ MY_ADDR SHALL be accepted and discarded without any state change, and err_dest SHALL pulse in the following cycle.
REQ-024 When filt_cnt==3 and ifm_ok are both true at the end of an accept cycle N (in either arrival order), the node SHALL enter MAC at N+1.
REQ-025 MAC SHALL take 9 cycles, indices 0..8, row-major; each cycle SHALL add the weight to a 12-bit accumulator when its spike bit is 1, and add nothing otherwise.
REQ-026 UPDATE SHALL last one cycle and compute s = potential_q + acc, saturated to 255.
REQ-027 In UPDATE, if s ≥ THRESHOLD, then spike SHALL be 1 and the new potential SHALL be s − THRESHOLD; otherwise spike SHALL be 0 and the new potential SHALL be s.
REQ-028 In UPDATE, the node SHALL clear filt_cnt, the row counter, ifm_ok and the accumulator.
REQ-029 out_valid SHALL rise at cycle N+11 carrying out_packet = {1'b0, MEM_ADDR, MY_ADDR, 15'b0, spike, potential[7:0]}.
REQ-030 out_packet and out_valid SHALL be held stable until out_ready is sampled high; the node SHALL then return to COLLECT in the next cycle.
REQ-031 Input arriving while in_ready is 0 SHALL NOT be consumed; the upstream holds it.
REQ-032 potential_q SHALL persist across timesteps and change only in UPDATE or on reset.

Reset
REQ-033 Asserting reset at any time, including mid-MAC or mid-SEND, SHALL immediately force: state COLLECT, in_ready 1, out_valid 0, out_packet 0, potential_q 0, busy 0, err_dest 0, filt_cnt 0, row counter 0, ifm_ok 0, accumulator 0, and all weights and spikes 0.
REQ-034 After reset deasserts, the first rising edge SHALL be able to accept a packet.

Verification
REQ-035 The bench SHALL cover: three filter rows {10,20,30} plus ifmap 9'h1FF, out_ready held 1 → out_valid 11 cycles after the last accept, out_packet = {0,D,5,15'b0,1,8'd116}.
REQ-036 The bench SHALL cover: repeating that timestep → s saturates to 255, result spike 1, potential 191.
REQ-037 The bench SHALL cover: after reset, row0 = {5,0,0}, rows 1 and 2 = 0, ifmap 9'b000000001 → spike 0, potential 5, out_packet = 33'h0_D500_0005.
REQ-038 The bench SHALL cover: a packet with dest 4'b0010 → err_dest pulses once, and a following valid set yields results identical to the case without it.
REQ-039 The bench SHALL cover: ifmap sent first, then 3 filters → MAC starts the cycle after the 3rd filter; a 4th filter sent before the ifmap overwrites row 0.
REQ-040 The bench SHALL cover: out_ready held 0 for 20 cycles → out_packet stable and in_ready 0 throughout; reset asserted in MAC cycle 4 → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/pe_node_engine.sv
// pe_node_engine: spiking-neuron processing element on a NoC.
// Collects a 3x3 filter (three row packets) and a 9-bit spike map, runs a
// 9-cycle multiply-accumulate, integrates the result into a persistent
// membrane potential, fires against THRESHOLD and sends the result to memory.
// Ports:
//   clk, reset               - rising-edge clock, async active-high reset
//   in_packet/in_valid/in_ready    - incoming NoC packet handshake
//   out_packet/out_valid/out_ready - result packet handshake toward memory
//   potential_q              - stored membrane potential
//   busy                     - high whenever not collecting
//   err_dest                 - one-cycle pulse after a misaddressed packet
module pe_node_engine #(
    parameter logic [3:0] MY_ADDR   = 4'b0101,
    parameter logic [3:0] MEM_ADDR  = 4'b1101,
    parameter logic [7:0] THRESHOLD = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] in_packet,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] out_packet,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  potential_q,
    output logic        busy,
    output logic        err_dest
);
    localparam int unsigned ACC_W    = 12;
    localparam int unsigned SUM_W    = 13;
    localparam int unsigned NUM_TAPS = 9;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MAC     = 2'd1,
        UPDATE  = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       weight [NUM_TAPS];
    logic [8:0]       spikes;
    logic [1:0]       row_cnt;
    logic [1:0]       filt_cnt;
    logic [1:0]       filt_cnt_nxt;
    logic             ifm_ok;
    logic             ifm_ok_nxt;
    logic [3:0]       mac_idx;
    logic [ACC_W-1:0] acc;

    logic             accept_c;
    logic             dest_ok_c;
    logic             filt_wr_c;
    logic             ifm_wr_c;
    logic [SUM_W-1:0] sum_c;
    logic [7:0]       sat_c;
    logic             fire_c;
    logic [7:0]       pot_new_c;

    // Packet decode for the current accept
    assign accept_c  = in_valid && in_ready;
    assign dest_ok_c = (in_packet[31:28] == MY_ADDR);
    assign filt_wr_c = accept_c && dest_ok_c && !in_packet[32];
    assign ifm_wr_c  = accept_c && dest_ok_c &&  in_packet[32];

    // Counter/flag values as they will stand at the end of this cycle
    assign filt_cnt_nxt = (filt_wr_c && filt_cnt != 2'd3) ? filt_cnt + 2'd1 : filt_cnt;
    assign ifm_ok_nxt   = ifm_ok || ifm_wr_c;

    // Integrate-and-fire arithmetic used in UPDATE
    assign sum_c     = SUM_W'(potential_q) + SUM_W'(acc);
    assign sat_c     = (sum_c > SUM_W'(255)) ? 8'hFF : sum_c[7:0];
    assign fire_c    = (sat_c >= THRESHOLD);
    assign pot_new_c = fire_c ? (sat_c - THRESHOLD) : sat_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if ((filt_wr_c || ifm_wr_c) && filt_cnt_nxt == 2'd3 && ifm_ok_nxt) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (mac_idx == 4'd8) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    // Registered handshake/status outputs follow the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            err_dest  <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == COLLECT);
            busy      <= (state_nxt != COLLECT);
            out_valid <= (state_nxt == SEND);
            err_dest  <= accept_c && !dest_ok_c;
        end
    end

    // Filter/spike storage and collection bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                weight[i] <= 8'd0;
            end
            spikes   <= 9'd0;
            row_cnt  <= 2'd0;
            filt_cnt <= 2'd0;
            ifm_ok   <= 1'b0;
        end else if (state == UPDATE) begin
            row_cnt  <= 2'd0;
            filt_cnt <= 2'd0;
            ifm_ok   <= 1'b0;
        end else begin
            if (filt_wr_c) begin
                case (row_cnt)
                    2'd0:    {weight[2], weight[1], weight[0]} <= in_packet[23:0];
                    2'd1:    {weight[5], weight[4], weight[3]} <= in_packet[23:0];
                    2'd2:    {weight[8], weight[7], weight[6]} <= in_packet[23:0];
                    default: ;
                endcase
                row_cnt <= (row_cnt == 2'd2) ? 2'd0 : row_cnt + 2'd1;
            end
            if (ifm_wr_c) begin
                spikes <= in_packet[8:0];
            end
            filt_cnt <= filt_cnt_nxt;
            ifm_ok   <= ifm_ok_nxt;
        end
    end

    // Row-major MAC walk over the 9 taps; index doubles as weight/spike index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_idx <= 4'd0;
            acc     <= '0;
        end else if (state == MAC) begin
            mac_idx <= mac_idx + 4'd1;
            if (spikes[mac_idx]) begin
                acc <= acc + ACC_W'(weight[mac_idx]);
            end
        end else begin
            mac_idx <= 4'd0;
            if (state == UPDATE) begin
                acc <= '0;
            end
        end
    end

    // Potential update and result packet; packet holds through SEND
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            potential_q <= 8'd0;
            out_packet  <= 33'd0;
        end else if (state == UPDATE) begin
            potential_q <= pot_new_c;
            out_packet  <= {1'b0, MEM_ADDR, MY_ADDR, 15'b0, fire_c, pot_new_c};
        end
    end

endmodule

// File: tb/tb_pe_node_engine.sv
// Self-checking bench for pe_node_engine: directed timesteps plus random
// packet traffic, with a reference model feeding a scoreboard queue.
module tb_pe_node_engine;
    localparam logic [3:0] MY  = 4'h5;
    localparam logic [3:0] MEM = 4'hD;
    localparam int         THR = 64;

    typedef struct {
        logic [32:0] pkt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] in_packet = 33'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] out_packet;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  potential_q;
    logic        busy;
    logic        err_dest;

    logic fixed_rdy = 1'b1;
    logic rand_rdy  = 1'b0;
    logic rr        = 1'b1;
    assign out_ready = rand_rdy ? rr : fixed_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic prev_ov = 1'b0;
    exp_t q[$];

    // Reference model state: weights row-major, spike map, potential
    int       mw[9];
    logic [8:0] ms;
    int       mrow, mfc, mpot;
    bit       mok;

    pe_node_engine #(.MY_ADDR(4'b0101), .MEM_ADDR(4'b1101), .THRESHOLD(8'd64)) dut (
        .clk(clk), .reset(reset),
        .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
        .out_packet(out_packet), .out_valid(out_valid), .out_ready(out_ready),
        .potential_q(potential_q), .busy(busy), .err_dest(err_dest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rr <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] mk(input logic t, input logic [3:0] d, input logic [23:0] data);
        return {t, d, 4'h3, data};
    endfunction

    function automatic logic [32:0] filt(input int a, input int b, input int c);
        return mk(1'b0, MY, {8'(c), 8'(b), 8'(a)});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mw[i] = 0;
        ms = 9'd0; mrow = 0; mfc = 0; mpot = 0; mok = 0;
        q.delete();
    endtask

    // Applies one accepted packet to the model; a completed set yields a result
    task automatic model_accept(input logic [32:0] p, input int c);
        int a, s;
        logic sp;
        exp_t e;
        if (p[31:28] != MY) begin
            err_exp++;
            return;
        end
        if (!p[32]) begin
            for (int k = 0; k < 3; k++) mw[mrow*3 + k] = int'(p[8*k +: 8]);
            mrow = (mrow + 1) % 3;
            if (mfc < 3) mfc++;
        end else begin
            ms = p[8:0];
            mok = 1;
        end
        if (mfc == 3 && mok) begin
            a = 0;
            for (int i = 0; i < 9; i++) if (ms[i]) a += mw[i];
            s = mpot + a;
            if (s > 255) s = 255;
            if (s >= THR) begin sp = 1'b1; mpot = s - THR; end
            else begin sp = 1'b0; mpot = s; end
            e.pkt = {1'b0, MEM, MY, 15'b0, sp, 8'(mpot)};
            e.cyc = c + 11;
            q.push_back(e);
            mfc = 0; mrow = 0; mok = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic send(input logic [32:0] p);
        int n = 0;
        in_packet = p;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
        end else begin
            model_accept(p, cyc);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // After the final accept, the result appears 11 cycles after the accept cycle
    task automatic expect_result(input string name, input logic [32:0] exp);
        repeat (10) @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_pkt"}, 64'(out_packet), 64'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: result timing on rising out_valid, content at handshake
    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (err_dest) err_seen++;
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'(0));
                else check("result_latency", 64'(cyc), 64'(q[0].cyc));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                check("sb_out_packet", 64'(out_packet), 64'(q[0].pkt));
                check("sb_potential", 64'(potential_q), 64'(q[0].pkt[7:0]));
                void'(q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int n;
        logic [3:0] bd;
        model_reset();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_potential", 64'(potential_q), 64'(0));
        reset = 1'b0;

        // Basic timestep, then repeat to saturate
        send(filt(10, 20, 30)); send(filt(10, 20, 30)); send(filt(10, 20, 30));
        send(mk(1'b1, MY, 24'h1FF));
        expect_result("ts1", 33'h0_D500_0174);
        @(negedge clk);
        send(filt(10, 20, 30)); send(filt(10, 20, 30)); send(filt(10, 20, 30));
        send(mk(1'b1, MY, 24'h1FF));
        expect_result("ts2_sat", 33'h0_D500_01BF);
        @(negedge clk);

        // Small result from a fresh potential
        do_reset();
        send(filt(5, 0, 0)); send(filt(0, 0, 0)); send(filt(0, 0, 0));
        send(mk(1'b1, MY, 24'h001));
        expect_result("small", 33'h0_D500_0005);
        @(negedge clk);

        // Misaddressed packet in the middle of a set
        send(filt(1, 2, 3));
        send(mk(1'b0, 4'b0010, 24'hFFFFFF));
        check("err_pulse", 64'(err_dest), 64'(1));
        @(negedge clk);
        check("err_one_cycle", 64'(err_dest), 64'(0));
        send(filt(4, 5, 6)); send(filt(7, 8, 9));
        send(mk(1'b1, MY, 24'h155));
        repeat (14) @(negedge clk);

        // Ifmap first, MAC begins right after the third filter
        send(mk(1'b1, MY, 24'h0AA));
        send(filt(11, 12, 13)); send(filt(14, 15, 16));
        check("no_mac_early", 64'(busy), 64'(0));
        send(filt(17, 18, 19));
        check("mac_started_busy", 64'(busy), 64'(1));
        check("mac_started_in_ready", 64'(in_ready), 64'(0));
        repeat (14) @(negedge clk);

        // Fourth filter before ifmap overwrites row 0
        send(filt(1, 1, 1)); send(filt(2, 2, 2)); send(filt(3, 3, 3));
        send(filt(9, 9, 9));
        send(mk(1'b1, MY, 24'h007));
        repeat (14) @(negedge clk);

        // Back-pressure: result held while out_ready is low
        fixed_rdy = 1'b0;
        send(filt(20, 0, 0)); send(filt(0, 0, 0)); send(filt(0, 0, 0));
        send(mk(1'b1, MY, 24'h001));
        repeat (10) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (q.size() != 0) check("stall_pkt", 64'(out_packet), 64'(q[0].pkt));
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 fixed_rdy = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during MAC cycle 4 clears everything at once
        send(filt(50, 50, 50)); send(filt(50, 50, 50)); send(filt(50, 50, 50));
        send(mk(1'b1, MY, 24'h1FF));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_packet", 64'(out_packet), 64'(0));
        check("mid_rst_potential", 64'(potential_q), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_err", 64'(err_dest), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Random traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            n = int'($urandom_range(0, 9));
            if (n == 0) begin
                bd = 4'($urandom_range(0, 15));
                if (bd == MY) bd = 4'hA;
                send(mk(1'($urandom_range(0, 1)), bd, 24'($urandom)));
            end else if (n < 6) begin
                send(mk(1'b0, MY, 24'($urandom)));
            end else begin
                send(mk(1'b1, MY, 24'($urandom_range(0, 511))));
            end
        end

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_scoreboard", 64'(q.size()), 64'(0));
        check("err_pulse_count", 64'(err_seen), 64'(err_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
